// File: rtl/a2d_pkg.sv
// Shared types, constants and helpers for the A2D conversion interface.
// Divider compare points place MOSI shifts on SCLK falls and MISO samples on SCLK rises.
package a2d_pkg;

  localparam int unsigned SCLK_DIV_W = 5;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS);
  localparam int unsigned RES_W      = 12;

  localparam logic [SCLK_DIV_W-1:0] DIV_PRELOAD = 5'b10111;
  localparam logic [SCLK_DIV_W-1:0] DIV_SHIFT   = 5'b11111;
  localparam logic [SCLK_DIV_W-1:0] DIV_SAMPLE  = 5'b01111;

  typedef enum logic [1:0] {IDLE, TX1, GAP, TX2} a2d_state_t;
  typedef enum logic [1:0] {SPI_IDLE, SPI_ACTIVE, SPI_PORCH} spi_state_t;

  function automatic logic [FRAME_BITS-1:0] cmd_build(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

endpackage

// File: rtl/spi_mstr16.sv
// 16-bit SPI master: SCLK idles high, MOSI changes on SCLK falls, MISO sampled on SCLK rises.
// Each frame is bracketed by a 9-clk front porch and a back porch ending at the divider wrap.
module spi_mstr16
  import a2d_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wrt,
  input  logic [FRAME_BITS-1:0] cmd,
  output logic                  done,
  output logic [FRAME_BITS-1:0] rd_data,
  output logic                  SS_n,
  output logic                  SCLK,
  output logic                  MOSI,
  input  logic                  MISO
);

  spi_state_t state, nxt_state;

  logic [SCLK_DIV_W-1:0] div, div_inc;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [FRAME_BITS-1:0] tx_shreg, rx_shreg;
  logic                  load, smpl, shft, finish;

  assign div_inc = div + SCLK_DIV_W'(1);
  assign MOSI    = tx_shreg[FRAME_BITS-1];
  assign rd_data = rx_shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SPI_IDLE;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      SPI_IDLE:   if (wrt) nxt_state = SPI_ACTIVE;
      SPI_ACTIVE: if (smpl && (bit_cnt == '1)) nxt_state = SPI_PORCH;
      SPI_PORCH:  if (div == DIV_SHIFT) nxt_state = SPI_IDLE;
      default:    nxt_state = SPI_IDLE;
    endcase
  end

  // The first SCLK fall happens before any sample (bit_cnt still 0) and must not shift MOSI.
  always_comb begin
    load   = (state == SPI_IDLE) && wrt;
    smpl   = (state == SPI_ACTIVE) && (div == DIV_SAMPLE);
    shft   = (state == SPI_ACTIVE) && (div == DIV_SHIFT) && (bit_cnt != '0);
    finish = (state == SPI_PORCH) && (div == DIV_SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div      <= '0;
      bit_cnt  <= '0;
      tx_shreg <= '0;
      rx_shreg <= '0;
      SS_n     <= 1'b1;
      SCLK     <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        div      <= DIV_PRELOAD;
        bit_cnt  <= '0;
        tx_shreg <= cmd;
        SS_n     <= 1'b0;
        SCLK     <= 1'b1;
      end else if (finish) begin
        SS_n <= 1'b1;
        SCLK <= 1'b1;
      end else if (state != SPI_IDLE) begin
        div  <= div_inc;
        SCLK <= div_inc[SCLK_DIV_W-1];
      end
      if (shft) tx_shreg <= {tx_shreg[FRAME_BITS-2:0], 1'b0};
      if (smpl) begin
        rx_shreg <= {rx_shreg[FRAME_BITS-2:0], MISO};
        bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/a2d_intf.sv
// Conversion responder: on strt_cnv runs an address frame then a result frame to the A2D,
// then presents res with cnv_cmplt held until the next accepted request.
module a2d_intf
  import a2d_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strt_cnv,
  input  logic [2:0]       chnnl,
  output logic             cnv_cmplt,
  output logic [RES_W-1:0] res,
  output logic             a2d_SS_n,
  output logic             SCLK,
  output logic             MOSI,
  input  logic             MISO
);

  a2d_state_t state, nxt_state;

  logic                  wrt, done;
  logic [FRAME_BITS-1:0] cmd, rd_data;
  logic [3:0]            lead_unused;

  // The A2D's leading nibble carries no data.
  assign lead_unused = rd_data[FRAME_BITS-1:RES_W];

  spi_mstr16 u_spi (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (wrt),
    .cmd     (cmd),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (a2d_SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (strt_cnv) nxt_state = TX1;
      TX1:     if (done) nxt_state = GAP;
      GAP:     nxt_state = TX2;
      TX2:     if (done) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // The channel is latched by the SPI command shift register on the accept cycle itself.
  always_comb begin
    wrt = 1'b0;
    cmd = '0;
    case (state)
      IDLE: begin
        wrt = strt_cnv;
        cmd = cmd_build(chnnl);
      end
      GAP:     wrt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnv_cmplt <= 1'b0;
      res       <= '0;
    end else if ((state == IDLE) && strt_cnv) begin
      cnv_cmplt <= 1'b0;
    end else if ((state == TX2) && done) begin
      cnv_cmplt <= 1'b1;
      res       <= rd_data[RES_W-1:0];
    end
  end

endmodule
